jk_ff: RTL and testbench
========================

Name: jk_ff

Overview:
Edge-triggered JK flip-flop bank, WIDTH bits wide, with asynchronous active-high reset. Each bit follows classic JK semantics: hold, reset, set or toggle on the rising clock edge. It is a leaf storage primitive used wherever per-bit set/clear/toggle control is needed. The default configuration is a single JK flip-flop.

Parameters:
- WIDTH, 1, number of independent JK bits; legal range is 1 or more.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q while rst is asserted; WIDTH bits wide.

Ports:
- clk  input  1  clock; all state changes occur on its rising edge, except reset.
- rst  input  1  reset, asynchronous and active-high.
- j  input  WIDTH  per-bit J (set) control.
- k  input  WIDTH  per-bit K (clear) control.
- q  output  WIDTH  registered state.
- q_n  output  WIDTH  bitwise complement of q; combinational from q, with no extra register.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset assertion:
  - When rst rises, q takes RESET_VALUE immediately, without waiting for a clock edge.
  - While rst is high, q holds RESET_VALUE and clock edges are ignored regardless of j and k.
- Reset release: after rst falls, the first rising clk edge evaluates j and k normally. No synchronizer is inside the block; the caller meets recovery/removal timing.
- Per bit i, at each rising clk edge with rst low (j[i], k[i] -> next q[i]):
  - 0,0 -> q[i] (hold)
  - 0,1 -> 0 (reset)
  - 1,0 -> 1 (set)
  - 1,1 -> ~q[i] (toggle)
- Bit independence: bits are fully independent; no carry or interaction between bits.
- Latency: q updates one clock-to-q after the sampling edge. j and k are sampled only at the rising edge; changes between edges have no effect.
- Sustained toggle: j=k=1 held for N edges toggles q N times, so the output is a divide-by-2 of clk.
- Simultaneous events: if rst is high at a clock edge, reset wins.
- Power-up: before the first reset or valid clocking, q is unspecified; simulation may show X.
- X inputs: X on j or k at an active edge may propagate X to q in simulation. Synthesis makes no special handling.
- Implementation: a single always block sensitive to posedge clk and posedge rst. No latches. No gated clocks.

Test Plan:
- Async reset: WIDTH=1, q toggling, assert rst mid-cycle between edges -> q=0 before the next clk rise; q stays 0 across 3 edges with j=1,k=0.
- Set/hold: rst=0, j=1,k=0 for 2 edges -> q=1, q_n=0; then j=0,k=0 for 2 edges -> q stays 1.
- Toggle: from q=1, j=1,k=1 for 4 edges -> q sequence 0,1,0,1; the period of q is 2 clk periods.
- Clear: from q=1, j=0,k=1 for 1 edge -> q=0; a further 2 edges keep q=0.
- Reset priority: rst=1 with j=1,k=0 at the clk edge -> q=0. Release rst between edges -> the next edge sets q=1.
- Multi-bit: WIDTH=4, RESET_VALUE=4'b1010, reset -> q=4'b1010. Then j=4'b0011, k=4'b0101 for one edge -> bit0 toggles (0->1), bit1 set (1), bit2 cleared (0), bit3 hold (1) -> q=4'b1011.

Source files
------------

// File: rtl/jk_ff.sv
// ---------------------------------------------------------------------------
// jk_ff
//
// Purpose:
//   Bank of WIDTH independent edge-triggered JK flip-flops. On each rising
//   clock edge every bit holds, clears, sets or toggles according to its own
//   J/K pair. An asynchronous active-high reset loads RESET_VALUE at once.
//   There is no interaction or carry between bits.
//
// Parameters:
//   WIDTH        number of independent JK bits (1 or more)
//   RESET_VALUE  value loaded into q while rst is high (WIDTH bits)
//
// Ports:
//   clk  in   1      clock; state changes on its rising edge
//   rst  in   1      asynchronous active-high reset
//   j    in   WIDTH  per-bit set control
//   k    in   WIDTH  per-bit clear control
//   q    out  WIDTH  registered state
//   q_n  out  WIDTH  bitwise complement of q, combinational from q
// ---------------------------------------------------------------------------
module jk_ff #(
  parameter int unsigned            WIDTH       = 1,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_qNext;

  // Next-state decode, bit by bit. A case on the {j,k} pair keeps the four
  // JK behaviours explicit; any X on j/k falls to the default and yields X,
  // so unknown controls propagate in simulation rather than being masked.
  always_comb begin
    w_qNext = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b00:   w_qNext[i] = r_q[i];
        2'b01:   w_qNext[i] = 1'b0;
        2'b10:   w_qNext[i] = 1'b1;
        2'b11:   w_qNext[i] = ~r_q[i];
        default: w_qNext[i] = 1'bx;
      endcase
    end
  end

  // State register. Reset is asynchronous and takes priority over any clock
  // edge; release timing is the caller's responsibility.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= w_qNext;
    end
  end

  assign q   = r_q;
  assign q_n = ~r_q;

endmodule

// File: tb/tb_jk_ff.sv
// ---------------------------------------------------------------------------
// tb_jk_ff
//
// Directed bench for jk_ff. One instance uses the default single-bit
// configuration; a second instance is a 4-bit bank with a non-zero reset
// value. Inputs change 1 time unit after a rising edge and outputs are
// sampled 1 time unit after the edge that should have updated them.
// ---------------------------------------------------------------------------
module tb_jk_ff;

  logic       clk;
  logic       rst;
  logic       j;
  logic       k;
  logic       q;
  logic       q_n;

  logic       rst4;
  logic [3:0] j4;
  logic [3:0] k4;
  logic [3:0] q4;
  logic [3:0] q4_n;

  int vectorCount;
  int missCount;

  jk_ff dutSingle (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .k   (k),
    .q   (q),
    .q_n (q_n)
  );

  jk_ff #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) dutQuad (
    .clk (clk),
    .rst (rst4),
    .j   (j4),
    .k   (k4),
    .q   (q4),
    .q_n (q4_n)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Drive the single-bit J/K pair, then advance past one rising edge.
  task automatic applyStimulus(input logic jv, input logic kv);
    j = jv;
    k = kv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    rst  = 1'b1;
    j    = 1'b0;
    k    = 1'b0;
    rst4 = 1'b1;
    j4   = 4'b0000;
    k4   = 4'b0000;

    // Reset state of both instances
    @(posedge clk);
    #1;
    checkOutput("resetQ",      {3'b000, q},   4'b0000);
    checkOutput("resetQn",     {3'b000, q_n}, 4'b0001);
    checkOutput("quadResetQ",  q4,            4'b1010);
    checkOutput("quadResetQn", q4_n,          4'b0101);

    // Release reset between edges
    rst  = 1'b0;
    rst4 = 1'b0;

    // Set for two edges, then hold for two edges
    applyStimulus(1'b1, 1'b0);
    checkOutput("set1",  {3'b000, q},   4'b0001);
    applyStimulus(1'b1, 1'b0);
    checkOutput("set2",  {3'b000, q},   4'b0001);
    checkOutput("set2n", {3'b000, q_n}, 4'b0000);
    applyStimulus(1'b0, 1'b0);
    checkOutput("hold1", {3'b000, q},   4'b0001);
    applyStimulus(1'b0, 1'b0);
    checkOutput("hold2", {3'b000, q},   4'b0001);

    // Toggle four edges from q=1: 0,1,0,1
    applyStimulus(1'b1, 1'b1);
    checkOutput("tog1", {3'b000, q}, 4'b0000);
    applyStimulus(1'b1, 1'b1);
    checkOutput("tog2", {3'b000, q}, 4'b0001);
    applyStimulus(1'b1, 1'b1);
    checkOutput("tog3", {3'b000, q}, 4'b0000);
    applyStimulus(1'b1, 1'b1);
    checkOutput("tog4", {3'b000, q}, 4'b0001);

    // Clear from q=1, then two more clear edges
    applyStimulus(1'b0, 1'b1);
    checkOutput("clr1", {3'b000, q}, 4'b0000);
    applyStimulus(1'b0, 1'b1);
    checkOutput("clr2", {3'b000, q}, 4'b0000);
    applyStimulus(1'b0, 1'b1);
    checkOutput("clr3", {3'b000, q}, 4'b0000);

    // Toggle up to q=1, then assert reset mid-cycle
    applyStimulus(1'b1, 1'b1);
    checkOutput("preRst", {3'b000, q}, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRst",  {3'b000, q},   4'b0000);
    checkOutput("asyncRstN", {3'b000, q_n}, 4'b0001);

    // Reset wins over set for three edges
    applyStimulus(1'b1, 1'b0);
    checkOutput("rstHold1", {3'b000, q}, 4'b0000);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rstHold2", {3'b000, q}, 4'b0000);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rstHold3", {3'b000, q}, 4'b0000);

    // Release between edges; next edge sets
    #3;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("relSet", {3'b000, q}, 4'b0001);

    // Multi-bit: toggle, set, clear, hold on bits 0..3 from 1010
    j4 = 4'b0011;
    k4 = 4'b0101;
    @(posedge clk);
    #1;
    checkOutput("quadMix",  q4,   4'b1011);
    checkOutput("quadMixN", q4_n, 4'b0100);

    // Multi-bit: toggle all bits
    j4 = 4'b1111;
    k4 = 4'b1111;
    @(posedge clk);
    #1;
    checkOutput("quadTog", q4, 4'b0100);

    // Multi-bit: mid-cycle async reset back to 1010
    j4 = 4'b0000;
    k4 = 4'b0000;
    #2;
    rst4 = 1'b1;
    #1;
    checkOutput("quadAsyncRst", q4, 4'b1010);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
